// File: rtl/branch_mispred_tracker_pkg.sv
// Shared core types for branch writeback, squash redirect and ROB age ordering.
// Also holds the FSM encoding of the mispredict tracker.
package branch_mispred_tracker_pkg;

  localparam int ROB_IDX_W = 6;
  localparam int FTQ_IDX_W = 4;
  localparam int PC_W      = 32;

  typedef struct packed {
    logic                 flag;
    logic [ROB_IDX_W-1:0] idx;
  } robIdx_t;

  typedef logic [FTQ_IDX_W-1:0] ftqIdx_t;

  typedef struct packed {
    robIdx_t         rob_idx;
    ftqIdx_t         ftq_idx;
    logic            has_mispred;
    logic            branch_taken;
    logic [PC_W-1:0] target_pc;
    logic [PC_W-1:0] branch_npc;
  } branchwbInfo_t;

  typedef struct packed {
    logic            dueToBranch;
    logic            branch_taken;
    logic [PC_W-1:0] arch_pc;
  } squashInfo_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_SQUASH = 2'd2
  } mispredState_t;

  // The flag bit flips on every ROB wrap, so a differing flag inverts the index order.
  function automatic logic rob_older(robIdx_t a, robIdx_t b);
    if (a.flag == b.flag) begin
      return a.idx < b.idx;
    end
    return a.idx > b.idx;
  endfunction

endpackage

// File: rtl/branch_mispred_tracker_oldest_select.sv
// Combinational oldest-of-N selector over ROB indices; on an age tie the
// lower input number wins.
module oldest_select
  import branch_mispred_tracker_pkg::*;
#(
  parameter int N = 2,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_vld,
  input  robIdx_t [N-1:0]  i_rob_idx,
  output logic             o_vld,
  output logic [SEL_W-1:0] o_idx
);

  robIdx_t w_best;

  // Strictly-older replacement keeps the lower input on equal age.
  always_comb begin
    o_vld  = i_vld[0];
    o_idx  = '0;
    w_best = i_rob_idx[0];
    for (int p = 1; p < N; p++) begin
      if (i_vld[p] && (!o_vld || rob_older(i_rob_idx[p], w_best))) begin
        o_vld  = 1'b1;
        o_idx  = SEL_W'(p);
        w_best = i_rob_idx[p];
      end
    end
  end

endmodule

// File: rtl/branch_mispred_tracker.sv
// Tracks the oldest outstanding mispredicted branch across all BRU writeback
// ports and issues a one-cycle squash redirect when the ROB retires it.
module branch_mispred_tracker
  import branch_mispred_tracker_pkg::*;
#(
  parameter int NUM_BRU      = 2,
  parameter int COMMIT_WIDTH = 4,
  parameter int CNT_W        = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_BRU-1:0]        i_wb_vld,
  input  branchwbInfo_t [NUM_BRU-1:0] i_wb_info,
  input  logic [COMMIT_WIDTH-1:0]   i_commit_vld,
  input  robIdx_t [COMMIT_WIDTH-1:0] i_commit_rob_idx,
  input  logic                      i_flush,
  output logic                      o_pending,
  output robIdx_t                   o_pending_rob_idx,
  output logic                      o_squash_vld,
  output squashInfo_t               o_squash_info,
  output ftqIdx_t                   o_squash_ftq_idx,
  output logic [CNT_W-1:0]          o_mispred_cnt,
  output mispredState_t             o_dbg_state
);

  localparam int SEL_W = (NUM_BRU > 1) ? $clog2(NUM_BRU) : 1;

  mispredState_t r_state;
  mispredState_t w_state_nxt;
  branchwbInfo_t r_entry;
  branchwbInfo_t w_entry_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_inc;

  logic [NUM_BRU-1:0]  w_cand;
  robIdx_t [NUM_BRU-1:0] w_wb_rob;
  logic                w_win_vld;
  logic [SEL_W-1:0]    w_win_port;
  branchwbInfo_t       w_win;

  logic [1:0]          w_cmp_vld_in;
  robIdx_t [1:0]       w_cmp_rob;
  logic                w_cmp_vld;
  logic                w_cmp_idx;
  logic                w_replace;
  logic                w_commit_hit;
  logic                w_squash;

  always_comb begin
    w_cand   = '0;
    w_wb_rob = '0;
    for (int p = 0; p < NUM_BRU; p++) begin
      w_cand[p]   = i_wb_vld[p] & i_wb_info[p].has_mispred;
      w_wb_rob[p] = i_wb_info[p].rob_idx;
    end
  end

  oldest_select #(.N(NUM_BRU)) u_wb_sel (
    .i_vld     (w_cand),
    .i_rob_idx (w_wb_rob),
    .o_vld     (w_win_vld),
    .o_idx     (w_win_port)
  );

  assign w_win = i_wb_info[w_win_port];

  // Held entry sits on input 0 so an equal-age winner never displaces it.
  assign w_cmp_vld_in = {w_win_vld, r_entry.has_mispred};
  assign w_cmp_rob    = {w_win.rob_idx, r_entry.rob_idx};

  oldest_select #(.N(2)) u_held_sel (
    .i_vld     (w_cmp_vld_in),
    .i_rob_idx (w_cmp_rob),
    .o_vld     (w_cmp_vld),
    .o_idx     (w_cmp_idx)
  );

  assign w_replace = w_cmp_vld & w_cmp_idx;

  always_comb begin
    w_commit_hit = 1'b0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (i_commit_vld[k] && (i_commit_rob_idx[k] == r_entry.rob_idx)) begin
        w_commit_hit = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_entry_nxt = r_entry;
    w_cnt_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_entry_nxt = w_win;
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_commit_hit) begin
          w_state_nxt = ST_SQUASH;
        end else if (w_replace) begin
          w_entry_nxt = w_win;
        end
      end
      ST_SQUASH: begin
        w_state_nxt = ST_IDLE;
        w_entry_nxt = '0;
        w_cnt_inc   = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_entry_nxt = '0;
      end
    endcase
    if (i_flush) begin
      w_state_nxt = ST_IDLE;
      w_entry_nxt = '0;
      w_cnt_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_entry <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_entry <= w_entry_nxt;
      if (w_cnt_inc && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // A flush in the squash cycle cancels the redirect it would have issued.
  assign w_squash = (r_state == ST_SQUASH) && !i_flush;

  always_comb begin
    o_squash_info    = '0;
    o_squash_ftq_idx = '0;
    if (w_squash) begin
      o_squash_info.dueToBranch  = 1'b1;
      o_squash_info.branch_taken = r_entry.branch_taken;
      o_squash_info.arch_pc      = r_entry.branch_taken ? r_entry.target_pc
                                                        : r_entry.branch_npc;
      o_squash_ftq_idx           = r_entry.ftq_idx;
    end
  end

  assign o_pending         = (r_state == ST_PEND);
  assign o_pending_rob_idx = o_pending ? r_entry.rob_idx : '0;
  assign o_squash_vld      = w_squash;
  assign o_mispred_cnt     = r_cnt;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_branch_mispred_tracker.sv
// Randomized and directed bench for branch_mispred_tracker against a
// sequence-number reference model of the oldest-mispredict rules.
module tb_branch_mispred_tracker;
  import branch_mispred_tracker_pkg::*;

  localparam int NUM_BRU      = 2;
  localparam int COMMIT_WIDTH = 4;
  localparam int CNT_W        = 32;
  localparam int NCNT_W       = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NUM_BRU-1:0]         i_wb_vld;
  branchwbInfo_t [NUM_BRU-1:0] i_wb_info;
  logic [COMMIT_WIDTH-1:0]    i_commit_vld;
  robIdx_t [COMMIT_WIDTH-1:0] i_commit_rob_idx;
  logic                       i_flush;

  logic          o_pending;
  robIdx_t       o_pending_rob_idx;
  logic          o_squash_vld;
  squashInfo_t   o_squash_info;
  ftqIdx_t       o_squash_ftq_idx;
  logic [CNT_W-1:0] o_mispred_cnt;
  mispredState_t o_dbg_state;

  logic          n_pending;
  robIdx_t       n_pending_rob_idx;
  logic          n_squash_vld;
  squashInfo_t   n_squash_info;
  ftqIdx_t       n_squash_ftq_idx;
  logic [NCNT_W-1:0] n_cnt;
  mispredState_t n_dbg_state;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model
  bit            m_held_vld;
  branchwbInfo_t m_held;
  bit            m_sq;
  branchwbInfo_t m_sq_ent;
  longint        m_cnt;

  always #5 clk = ~clk;

  branch_mispred_tracker #(
    .NUM_BRU(NUM_BRU), .COMMIT_WIDTH(COMMIT_WIDTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .i_wb_vld(i_wb_vld), .i_wb_info(i_wb_info),
    .i_commit_vld(i_commit_vld), .i_commit_rob_idx(i_commit_rob_idx),
    .i_flush(i_flush),
    .o_pending(o_pending), .o_pending_rob_idx(o_pending_rob_idx),
    .o_squash_vld(o_squash_vld), .o_squash_info(o_squash_info),
    .o_squash_ftq_idx(o_squash_ftq_idx), .o_mispred_cnt(o_mispred_cnt),
    .o_dbg_state(o_dbg_state)
  );

  branch_mispred_tracker #(
    .NUM_BRU(NUM_BRU), .COMMIT_WIDTH(COMMIT_WIDTH), .CNT_W(NCNT_W)
  ) dut_sat (
    .clk(clk), .rst(rst),
    .i_wb_vld(i_wb_vld), .i_wb_info(i_wb_info),
    .i_commit_vld(i_commit_vld), .i_commit_rob_idx(i_commit_rob_idx),
    .i_flush(i_flush),
    .o_pending(n_pending), .o_pending_rob_idx(n_pending_rob_idx),
    .o_squash_vld(n_squash_vld), .o_squash_info(n_squash_info),
    .o_squash_ftq_idx(n_squash_ftq_idx), .o_mispred_cnt(n_cnt),
    .o_dbg_state(n_dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Age as distance on the 7-bit {flag,idx} sequence circle.
  function automatic bit m_older(robIdx_t a, robIdx_t b);
    logic [6:0] av;
    logic [6:0] bv;
    logic [6:0] d;
    av = a;
    bv = b;
    d  = bv - av;
    return (d != 7'd0) && (d < 7'd64);
  endfunction

  task automatic model_reset();
    m_held_vld = 0;
    m_held     = '0;
    m_sq       = 0;
    m_sq_ent   = '0;
    m_cnt      = 0;
  endtask

  task automatic model_update();
    bit was_sq;
    bit hit;
    int best;
    if (m_sq && !i_flush) m_cnt++;
    was_sq = m_sq;
    m_sq   = 0;
    if (i_flush) begin
      m_held_vld = 0;
    end else if (!was_sq) begin
      hit = 0;
      for (int k = 0; k < COMMIT_WIDTH; k++)
        if (m_held_vld && i_commit_vld[k] && i_commit_rob_idx[k] == m_held.rob_idx) hit = 1;
      if (hit) begin
        m_sq       = 1;
        m_sq_ent   = m_held;
        m_held_vld = 0;
      end else begin
        best = -1;
        for (int p = 0; p < NUM_BRU; p++)
          if (i_wb_vld[p] && i_wb_info[p].has_mispred &&
              (best < 0 || m_older(i_wb_info[p].rob_idx, i_wb_info[best].rob_idx)))
            best = p;
        if (best >= 0 && (!m_held_vld || m_older(i_wb_info[best].rob_idx, m_held.rob_idx))) begin
          m_held     = i_wb_info[best];
          m_held_vld = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    squashInfo_t e_info;
    ftqIdx_t     e_ftq;
    bit          e_sq;
    robIdx_t     e_pidx;
    longint      e_ncnt;
    e_sq   = m_sq && !i_flush;
    e_info = '0;
    e_ftq  = '0;
    if (e_sq) begin
      e_info.dueToBranch  = 1'b1;
      e_info.branch_taken = m_sq_ent.branch_taken;
      e_info.arch_pc      = m_sq_ent.branch_taken ? m_sq_ent.target_pc : m_sq_ent.branch_npc;
      e_ftq               = m_sq_ent.ftq_idx;
    end
    e_pidx = m_held_vld ? m_held.rob_idx : robIdx_t'(0);
    e_ncnt = (m_cnt > 3) ? 3 : m_cnt;
    chk("pending", o_pending, m_held_vld);
    chk("pending_rob_idx", o_pending_rob_idx, e_pidx);
    chk("squash_vld", o_squash_vld, e_sq);
    chk("squash_info", o_squash_info, e_info);
    chk("squash_ftq_idx", o_squash_ftq_idx, e_ftq);
    chk("mispred_cnt", o_mispred_cnt, m_cnt);
    chk("sat_cnt", n_cnt, e_ncnt);
    chk("sat_squash_vld", n_squash_vld, e_sq);
  endtask

  // driver tasks: inputs change on the falling edge only
  task automatic clear_inputs();
    i_wb_vld         = '0;
    i_wb_info        = '0;
    i_commit_vld     = '0;
    i_commit_rob_idx = '0;
    i_flush          = 1'b0;
  endtask

  task automatic set_wb(input int p, input logic [6:0] rob, input bit mis, input bit taken,
                        input logic [31:0] tgt, input logic [31:0] npc, input logic [3:0] ftq);
    i_wb_vld[p]               = 1'b1;
    i_wb_info[p].rob_idx      = rob;
    i_wb_info[p].has_mispred  = mis;
    i_wb_info[p].branch_taken = taken;
    i_wb_info[p].target_pc    = tgt;
    i_wb_info[p].branch_npc   = npc;
    i_wb_info[p].ftq_idx      = ftq;
  endtask

  task automatic set_commit(input int k, input logic [6:0] rob);
    i_commit_vld[k]     = 1'b1;
    i_commit_rob_idx[k] = rob;
  endtask

  task automatic run_cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic settle_clear();
    clear_inputs();
    #1;
  endtask

  task automatic rand_inputs();
    clear_inputs();
    for (int p = 0; p < NUM_BRU; p++)
      if ($urandom_range(0, 2) == 0)
        set_wb(p, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
    for (int k = 0; k < COMMIT_WIDTH; k++)
      if ($urandom_range(0, 7) == 0) set_commit(k, 7'($urandom_range(0, 127)));
    if (m_held_vld && $urandom_range(0, 3) == 0)
      set_commit($urandom_range(0, COMMIT_WIDTH - 1), m_held.rob_idx);
    i_flush = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_outputs();
    chk("reset_state", o_dbg_state, ST_IDLE);
    rst = 1'b1;
    @(negedge clk);

    // taken mispredict retired by commit slot 2
    set_wb(0, 7'h05, 1, 1, 32'h8000_0100, 32'h8000_0004, 4'd3);
    run_cycle();
    settle_clear();
    chk("t1_pending", o_pending, 1'b1);
    chk("t1_pending_idx", o_pending_rob_idx, 7'h05);
    set_commit(2, 7'h05);
    run_cycle();
    settle_clear();
    chk("t1_squash_vld", o_squash_vld, 1'b1);
    chk("t1_arch_pc", o_squash_info.arch_pc, 32'h8000_0100);
    chk("t1_taken", o_squash_info.branch_taken, 1'b1);
    chk("t1_ftq", o_squash_ftq_idx, 4'd3);
    run_cycle();
    settle_clear();
    chk("t1_cnt", o_mispred_cnt, 32'd1);

    // two ports at once, then a younger one
    set_wb(0, 7'h09, 1, 1, 32'h1000, 32'h1004, 4'd1);
    set_wb(1, 7'h03, 1, 1, 32'h2000, 32'h2004, 4'd2);
    run_cycle();
    settle_clear();
    chk("t2_oldest", o_pending_rob_idx, 7'h03);
    set_wb(0, 7'h07, 1, 0, 32'h3000, 32'h3004, 4'd5);
    run_cycle();
    settle_clear();
    chk("t2_keep", o_pending_rob_idx, 7'h03);
    set_commit(0, 7'h03);
    run_cycle();
    settle_clear();
    chk("t2_ftq", o_squash_ftq_idx, 4'd2);
    run_cycle();

    // wrap: {0,62} is older than {1,1}
    set_wb(1, 7'h3E, 1, 1, 32'h4000, 32'h4004, 4'd6);
    run_cycle();
    set_wb(0, 7'h41, 1, 1, 32'h5000, 32'h5004, 4'd7);
    run_cycle();
    settle_clear();
    chk("t3_wrap_keep", o_pending_rob_idx, 7'h3E);
    set_commit(3, 7'h3E);
    run_cycle();
    run_cycle();
    set_wb(0, 7'h41, 1, 1, 32'h5000, 32'h5004, 4'd7);
    run_cycle();
    set_wb(1, 7'h3E, 1, 0, 32'h6000, 32'h6004, 4'd8);
    run_cycle();
    settle_clear();
    chk("t3_wrap_replace", o_pending_rob_idx, 7'h3E);
    set_commit(1, 7'h3E);
    run_cycle();
    run_cycle();

    // not-taken mispredict redirects to npc
    set_wb(1, 7'h10, 1, 0, 32'h8000_0200, 32'h8000_0044, 4'd9);
    run_cycle();
    set_commit(0, 7'h10);
    run_cycle();
    settle_clear();
    chk("t4_arch_pc", o_squash_info.arch_pc, 32'h8000_0044);
    chk("t4_taken", o_squash_info.branch_taken, 1'b0);
    run_cycle();
    settle_clear();
    chk("t4_sat_cnt", n_cnt, 2'b11);

    // non-mispredict never stored; equal index tie goes to port 0
    set_wb(0, 7'h12, 0, 1, 32'h0, 32'h0, 4'd1);
    run_cycle();
    settle_clear();
    chk("t5_no_store", o_pending, 1'b0);
    set_wb(0, 7'h14, 1, 1, 32'h0, 32'h0, 4'd10);
    set_wb(1, 7'h14, 1, 1, 32'h0, 32'h0, 4'd11);
    run_cycle();
    settle_clear();
    chk("t5_tie_state", o_dbg_state, ST_PEND);

    // flush together with a commit match: no pulse, counter held
    set_commit(0, 7'h14);
    i_flush = 1'b1;
    run_cycle();
    settle_clear();
    chk("t6_state", o_dbg_state, ST_IDLE);
    chk("t6_no_pulse", o_squash_vld, 1'b0);
    chk("t6_cnt", o_mispred_cnt, 32'd5);
    run_cycle();

    // writebacks during the squash cycle are dropped
    set_wb(0, 7'h20, 1, 1, 32'h0, 32'h0, 4'd1);
    run_cycle();
    set_commit(1, 7'h20);
    run_cycle();
    set_wb(1, 7'h21, 1, 1, 32'h0, 32'h0, 4'd2);
    run_cycle();
    settle_clear();
    chk("t7_drop", o_pending, 1'b0);

    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      run_cycle();
    end

    // reset asserted inside the squash cycle
    clear_inputs();
    set_wb(0, 7'h28, 1, 1, 32'h9000, 32'h9004, 4'd4);
    run_cycle();
    set_commit(0, 7'h28);
    run_cycle();
    settle_clear();
    chk("t8_pulse_before", o_squash_vld, 1'b1);
    rst = 1'b0;
    #1;
    chk("t8_squash_vld", o_squash_vld, 1'b0);
    chk("t8_pending", o_pending, 1'b0);
    chk("t8_pending_idx", o_pending_rob_idx, 7'h00);
    chk("t8_info", o_squash_info, 34'h0);
    chk("t8_ftq", o_squash_ftq_idx, 4'd0);
    chk("t8_cnt", o_mispred_cnt, 32'd0);
    chk("t8_state", o_dbg_state, ST_IDLE);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) run_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
